// File: rtl/direction_pkg.sv
// Shared types and constants for the direction demultiplexer: FSM states,
// direction codes and the captured request record.
package direction_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam int CNT_W = 8;

  typedef struct packed {
    logic [1:0] dir;
    logic       data;
  } req_t;
endpackage

// File: rtl/direction_demux_hold_counter.sv
// 8-bit loadable down-counter that saturates at zero; times HOLD and GAP phases.
module hold_counter
  import direction_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (en && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/direction_demux.sv
// Routes a one-bit request to one of four direction lines for HOLD_CYCLES,
// then idles GAP_CYCLES before accepting the next request.
module direction_demux
  import direction_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  output logic ready,
  input  logic select1,
  input  logic select0,
  input  logic in,
  output logic up,
  output logic right,
  output logic down,
  output logic left,
  output logic busy
);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);

  state_t           state, state_n;
  req_t             req_q, req_n;
  logic             accept;
  logic             cnt_ld, cnt_en, cnt_zero;
  logic [CNT_W-1:0] cnt_ld_val;
  logic [3:0]       dec_n, out_q;

  assign accept = valid & ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req_q <= '0;
      out_q <= '0;
    end else begin
      state <= state_n;
      req_q <= req_n;
      out_q <= dec_n;
    end
  end

  always_comb begin
    state_n = state;
    req_n   = req_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          req_n = '{dir: {select1, select0}, data: in};
          if (in) state_n = HOLD;
        end
      end
      HOLD:    if (cnt_zero) state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:     if (cnt_zero) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Counter is loaded on entry to HOLD and GAP, and free-runs down inside them.
  always_comb begin
    cnt_ld     = 1'b0;
    cnt_en     = 1'b0;
    cnt_ld_val = HOLD_LD;
    if (state == IDLE && accept && in) begin
      cnt_ld = 1'b1;
    end else if (state == HOLD && cnt_zero && GAP_CYCLES != 0) begin
      cnt_ld     = 1'b1;
      cnt_ld_val = GAP_LD;
    end else if (state != IDLE) begin
      cnt_en = 1'b1;
    end
  end

  hold_counter u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_ld),
    .en       (cnt_en),
    .load_val (cnt_ld_val),
    .zero     (cnt_zero)
  );

  // Decode from next state so the registered lines track HOLD exactly.
  always_comb begin
    ready = (state == IDLE);
    busy  = ~ready;
    dec_n = '0;
    if (state_n == HOLD && req_n.data) begin
      unique case (req_n.dir)
        DIR_UP:    dec_n = 4'b0001;
        DIR_RIGHT: dec_n = 4'b0010;
        DIR_DOWN:  dec_n = 4'b0100;
        DIR_LEFT:  dec_n = 4'b1000;
        default:   dec_n = '0;
      endcase
    end
  end

  assign {left, down, right, up} = out_q;
endmodule

// File: tb/tb_direction_demux.sv
// Self-checking bench: table of single requests plus hand sequences, with a
// scoreboard of per-cycle expected {up,right,down,left,ready,busy}.
module tb_direction_demux;
  localparam int H0 = 4;
  localparam int G0 = 1;

  logic clk = 1'b0;
  logic rst;
  logic v0, i0, v1, i1;
  logic [1:0] s0, s1;
  logic rdy0, bsy0, up0, rt0, dn0, lf0;
  logic rdy1, bsy1, up1, rt1, dn1, lf1;

  always #5 clk = ~clk;

  direction_demux dut0 (
    .clk(clk), .rst(rst), .valid(v0), .ready(rdy0),
    .select1(s0[1]), .select0(s0[0]), .in(i0),
    .up(up0), .right(rt0), .down(dn0), .left(lf0), .busy(bsy0)
  );

  direction_demux #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut1 (
    .clk(clk), .rst(rst), .valid(v1), .ready(rdy1),
    .select1(s1[1]), .select0(s1[0]), .in(i1),
    .up(up1), .right(rt1), .down(dn1), .left(lf1), .busy(bsy1)
  );

  typedef struct {
    bit         which;
    logic [3:0] o;
    logic       rdy;
    logic       bsy;
  } exp_t;

  typedef struct {
    logic [1:0] code;
    logic       din;
    logic [3:0] exp_o;
  } vec_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic push(input bit w, input logic [3:0] o, input logic r, input logic b);
    exp_t e;
    e.which = w; e.o = o; e.rdy = r; e.bsy = b;
    q.push_back(e);
  endtask

  task automatic step(input string tag);
    exp_t e;
    logic [5:0] act, want;
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      act  = e.which ? {up1, rt1, dn1, lf1, rdy1, bsy1} : {up0, rt0, dn0, lf0, rdy0, bsy0};
      want = {e.o, e.rdy, e.bsy};
      checks++;
      if (act !== want) begin
        errors++;
        $display("FAIL %s dut%0d {urdl,rdy,bsy} got %b want %b", tag, e.which, act, want);
      end
    end
  endtask

  task automatic run_req(input logic [1:0] code, input logic din, input logic [3:0] exp_o,
                         input string tag);
    s0 = code; i0 = din; v0 = 1'b1;
    if (din) begin
      push(0, exp_o, 0, 1); step(tag);
      v0 = 1'b0; i0 = 1'b0;
      for (int i = 1; i < H0; i++) begin push(0, exp_o, 0, 1); step(tag); end
      for (int i = 0; i < G0; i++) begin push(0, 4'b0000, 0, 1); step({tag, "_gap"}); end
      push(0, 4'b0000, 1, 0); step({tag, "_rdy"});
    end else begin
      push(0, 4'b0000, 1, 0); step(tag);
      v0 = 1'b0;
      push(0, 4'b0000, 1, 0); step(tag);
    end
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{2'b00, 1'b1, 4'b1000};
    tbl[1] = '{2'b01, 1'b1, 4'b0100};
    tbl[2] = '{2'b10, 1'b1, 4'b0010};
    tbl[3] = '{2'b11, 1'b1, 4'b0001};
    tbl[4] = '{2'b10, 1'b0, 4'b0000};
    tbl[5] = '{2'b01, 1'b1, 4'b0100};

    rst = 1'b1; v0 = 0; i0 = 0; s0 = 0; v1 = 0; i1 = 0; s1 = 0;

    // Reset for two cycles; a request during reset must be ignored.
    push(0, 4'b0000, 1, 0); push(1, 4'b0000, 1, 0); step("reset1");
    v0 = 1'b1; s0 = 2'b01; i0 = 1'b1;
    push(0, 4'b0000, 1, 0); push(1, 4'b0000, 1, 0); step("reset2");
    rst = 1'b0; v0 = 1'b0; i0 = 1'b0;
    push(0, 4'b0000, 1, 0); push(1, 4'b0000, 1, 0); step("post_reset");

    for (int n = 0; n < 6; n++)
      run_req(tbl[n].code, tbl[n].din, tbl[n].exp_o, $sformatf("vec%0d", n));

    // Valid held with a new code during a code-00 hold; left waits for ready.
    s0 = 2'b00; i0 = 1'b1; v0 = 1'b1;
    push(0, 4'b1000, 0, 1); step("held_up");
    s0 = 2'b11;
    for (int i = 1; i < H0; i++) begin push(0, 4'b1000, 0, 1); step("held_up"); end
    push(0, 4'b0000, 0, 1); step("held_gap");
    push(0, 4'b0000, 1, 0); step("held_rdy");
    push(0, 4'b0001, 0, 1); step("held_left");
    v0 = 1'b0; i0 = 1'b0;
    for (int i = 1; i < H0; i++) begin push(0, 4'b0001, 0, 1); step("held_left"); end
    push(0, 4'b0000, 0, 1); step("held_gap2");
    push(0, 4'b0000, 1, 0); step("held_rdy2");

    // Reset on the second HOLD cycle of a code-10 request.
    s0 = 2'b10; i0 = 1'b1; v0 = 1'b1;
    push(0, 4'b0010, 0, 1); step("midrst_hold1");
    v0 = 1'b0; i0 = 1'b0;
    push(0, 4'b0010, 0, 1); step("midrst_hold2");
    rst = 1'b1;
    push(0, 4'b0000, 1, 0); push(1, 4'b0000, 1, 0); step("midrst_edge");
    rst = 1'b0;
    push(0, 4'b0000, 1, 0); step("midrst_after");

    // HOLD_CYCLES=1, GAP_CYCLES=0: back-to-back code-00 requests.
    s1 = 2'b00; i1 = 1'b1; v1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) push(1, 4'b1000, 0, 1);
      else            push(1, 4'b0000, 1, 0);
      step($sformatf("min_b2b%0d", i));
    end
    v1 = 1'b0;
    push(1, 4'b0000, 1, 0); step("min_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/direction_demux.md
DIRECTION_DEMUX -- requirements
Module: direction_demux

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-high reset.
REQ-002 Parameter HOLD_CYCLES SHALL default to 4 and set the number of cycles a routed output stays high; legal range 1..255.
REQ-003 Parameter GAP_CYCLES SHALL default to 1 and set the number of idle cycles after a hold; legal range 0..255, where 0 means no gap.
REQ-004 Port clk SHALL be an input, 1 bit wide, and is the rising-edge clock.
REQ-005 Port rst SHALL be an input, 1 bit wide, and is the synchronous active-high reset.
REQ-006 Port valid SHALL be an input, 1 bit wide, and indicates that a request is presented.
REQ-007 Port ready SHALL be an output, 1 bit wide, and indicates that the block can accept a request.
REQ-008 Ports select1 and select0 SHALL be inputs, 1 bit each, and together form the direction code {select1,select0}.
REQ-009 Port in SHALL be an input, 1 bit wide, and is the data bit to route.
REQ-010 Ports up, right, down and left SHALL be outputs, 1 bit each, and are the routed direction lines.
REQ-011 Port busy SHALL be an output, 1 bit wide, and is high in any state other than IDLE.

Function
REQ-012 The direction code SHALL map as follows: 00 to up, 01 to right, 10 to down, 11 to left.
REQ-013 A request SHALL be accepted on a rising edge where valid=1 and ready=1.
REQ-014 While valid=1 and ready=0, the request SHALL NOT be accepted, and no request state SHALL be captured.
REQ-015 The state machine SHALL have exactly three states: IDLE, HOLD and GAP.
REQ-016 ready SHALL be 1 only in IDLE, and busy SHALL equal the inverse of ready.
REQ-017 On acceptance with in=1 at edge k, the state SHALL move to HOLD and the captured direction SHALL be stored.
REQ-018 After an accept with in=1 at edge k, the selected output SHALL be high for cycles k+1 through k+HOLD_CYCLES.
REQ-019 On acceptance with in=0, the state SHALL remain IDLE, all outputs SHALL stay 0, and ready SHALL remain 1.
REQ-020 In HOLD, a down-counter SHALL load HOLD_CYCLES-1 on entry and decrement each cycle.
REQ-021 When the HOLD counter reaches 0, the state SHALL go to GAP, or to IDLE if GAP_CYCLES=0.
REQ-022 In GAP, all four outputs SHALL be 0, and the counter SHALL run GAP_CYCLES cycles before the return to IDLE.
REQ-023 ready SHALL return to 1 at cycle k+HOLD_CYCLES+GAP_CYCLES+1.
REQ-024 Changes on select1, select0, in or valid during HOLD or GAP SHALL have no effect on the outputs.
REQ-025 The outputs up, right, down and left SHALL be registered and SHALL always be one-hot or all-zero.
REQ-026 The counter width SHALL be 8 bits, and the counter SHALL never wrap below 0.
REQ-027 With HOLD_CYCLES=1, the output SHALL be high for exactly one cycle.
REQ-028 A request that arrives back-to-back with the return to IDLE SHALL be accepted on the first cycle where ready=1.

Reset
REQ-029 While rst=1 at a rising edge, the next state SHALL be IDLE, and the counter, the stored direction and the stored data SHALL be cleared to 0.
REQ-030 After reset, up, right, down, left and busy SHALL be 0, and ready SHALL be 1.
REQ-031 Reset asserted during HOLD or GAP SHALL force all outputs to 0 on the next edge, and any in-progress request SHALL be discarded.
REQ-032 A valid request presented in the same cycle as rst=1 SHALL be ignored.

Structure
REQ-033 The shared package direction_pkg SHALL hold the state enumeration (IDLE, HOLD, GAP) and the direction constants DIR_UP=2'b00, DIR_RIGHT=2'b01, DIR_DOWN=2'b10 and DIR_LEFT=2'b11.
REQ-034 One sub-module, hold_counter, SHALL be used: an 8-bit loadable down-counter with load, enable and a zero flag.
REQ-035 The output decode from the stored direction and data SHALL live in direction_demux itself.

Verification (HOLD_CYCLES=4, GAP_CYCLES=1 unless stated)
REQ-036 The bench SHALL cover reset: rst=1 for 2 cycles, then 0 -> outputs 0000, busy=0, ready=1.
REQ-037 The bench SHALL cover a single request: code 01, in=1, accepted at edge k -> right=1 for cycles k+1..k+4, all outputs 0 at k+5, ready=1 at k+6.
REQ-038 The bench SHALL cover all four codes: codes 00, 01, 10, 11 sequentially with in=1 -> up, right, down, left each high for 4 cycles, never two outputs high at once.
REQ-039 The bench SHALL cover valid held high while busy: valid=1, code 11, during the HOLD of a code-00 request -> left stays 0; left is accepted at the first ready=1 cycle.
REQ-040 The bench SHALL cover in=0: in=0, code 10 -> outputs 0000, ready stays 1, busy stays 0.
REQ-041 The bench SHALL cover reset mid-hold: rst=1 on the 2nd HOLD cycle of a code-10 request -> down=0 on the next edge, busy=0, ready=1.
REQ-042 The bench SHALL cover the minimum parameter case HOLD_CYCLES=1, GAP_CYCLES=0: back-to-back code-00 requests -> up high 1 cycle, ready high 1 cycle, repeating.
